// File: rtl/sdram_data_latch_if.sv
// CPU/controller-side and SDRAM-side signal bundle of the SDRAM data latch.
// master: controller + CPU + memory model; slave: the latch itself.
interface sdram_data_latch_if;
  logic        XFER_START;
  logic        WR;
  logic [3:0]  BE;
  logic [31:0] CPU_D_IN;
  logic [31:0] CPU_D_OUT;
  logic        CPU_D_OE;
  logic        RD_VALID;
  logic        WR_NEXT;
  logic [7:0]  SDRAM_DQ_IN;
  logic [7:0]  SDRAM_DQ_OUT;
  logic        SDRAM_DQ_OE;
  logic        SDRAM_DQM;
  logic        XFER_DONE;
  logic        XFER_ERR;

  modport master (
    output XFER_START, WR, BE, CPU_D_IN,
    output RD_VALID, WR_NEXT, SDRAM_DQ_IN,
    input  CPU_D_OUT, CPU_D_OE,
    input  SDRAM_DQ_OUT, SDRAM_DQ_OE, SDRAM_DQM,
    input  XFER_DONE, XFER_ERR
  );

  modport slave (
    input  XFER_START, WR, BE, CPU_D_IN,
    input  RD_VALID, WR_NEXT, SDRAM_DQ_IN,
    output CPU_D_OUT, CPU_D_OE,
    output SDRAM_DQ_OUT, SDRAM_DQ_OE, SDRAM_DQM,
    output XFER_DONE, XFER_ERR
  );
endinterface

// File: rtl/sdram_data_latch.sv
// 32-bit CPU word <-> 4-beat 8-bit SDRAM burst data latch.
// Little-endian beats, per-beat DQM, bounded read hold, beat timeout.
module sdram_data_latch #(
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input logic CLK,
  input logic RESET,
  sdram_data_latch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD_COLLECT,
    WR_SERIAL,
    RD_DRIVE
  } state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
  localparam logic [3:0] HOLD    = 4'(HOLD_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [9:0]  timer_q, timer_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cpu_d_out_q, cpu_d_out_d;
  logic        cpu_d_oe_q, cpu_d_oe_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        dqm_q, dqm_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        strobe;
  logic [31:0] rword;
  logic [1:0]  beat_nx;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cpu_d_out_d = cpu_d_out_q;
    cpu_d_oe_d  = cpu_d_oe_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    dqm_d       = dqm_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    strobe      = 1'b0;
    rword       = rdata_q;
    beat_nx     = beat_q + 2'd1;

    unique case (state_q)
      IDLE, RD_DRIVE: begin
        if (state_q == RD_DRIVE) begin
          if (hold_q == 4'd0) begin
            state_d    = IDLE;
            cpu_d_oe_d = 1'b0;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
        // A new transfer also cuts a read hold short.
        if (bus.XFER_START) begin
          cpu_d_oe_d = 1'b0;
          be_d       = bus.BE;
          wdata_d    = bus.CPU_D_IN;
          rdata_d    = 32'h0;
          beat_d     = 2'd0;
          timer_d    = 10'd0;
          if (bus.WR) begin
            state_d  = WR_SERIAL;
            dq_oe_d  = 1'b1;
            dq_out_d = bus.CPU_D_IN[7:0];
            dqm_d    = bus.BE[0];
          end else begin
            state_d = RD_COLLECT;
            dqm_d   = 1'b0;
          end
        end
      end
      RD_COLLECT: begin
        strobe = bus.RD_VALID;
        if (strobe) begin
          rword[{beat_q, 3'b000} +: 8] =
            be_q[beat_q] ? 8'h00 : bus.SDRAM_DQ_IN;
          rdata_d = rword;
          beat_d  = beat_nx;
          timer_d = 10'd0;
          if (beat_q == 2'd3) begin
            cpu_d_out_d = rword;
            cpu_d_oe_d  = 1'b1;
            done_d      = 1'b1;
            dqm_d       = 1'b1;
            hold_d      = HOLD;
            state_d     = RD_DRIVE;
          end
        end
      end
      WR_SERIAL: begin
        strobe = bus.WR_NEXT;
        if (strobe) begin
          beat_d  = beat_nx;
          timer_d = 10'd0;
          if (beat_q == 2'd3) begin
            dq_oe_d = 1'b0;
            dqm_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dq_out_d = wdata_q[{beat_nx, 3'b000} +: 8];
            dqm_d    = be_q[beat_nx];
          end
        end
      end
    endcase

    // Stalled controller: abandon the burst without touching CPU_D_OUT.
    if ((state_q == RD_COLLECT || state_q == WR_SERIAL) && !strobe) begin
      if (timer_q == TO_LAST) begin
        err_d      = 1'b1;
        cpu_d_oe_d = 1'b0;
        dq_oe_d    = 1'b0;
        dqm_d      = 1'b1;
        beat_d     = 2'd0;
        timer_d    = 10'd0;
        state_d    = IDLE;
      end else begin
        timer_d = timer_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      timer_q     <= 10'd0;
      hold_q      <= 4'd0;
      be_q        <= 4'hF;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      cpu_d_out_q <= 32'h0;
      cpu_d_oe_q  <= 1'b0;
      dq_out_q    <= 8'h0;
      dq_oe_q     <= 1'b0;
      dqm_q       <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cpu_d_out_q <= cpu_d_out_d;
      cpu_d_oe_q  <= cpu_d_oe_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      dqm_q       <= dqm_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.CPU_D_OUT    = cpu_d_out_q;
  assign bus.CPU_D_OE     = cpu_d_oe_q;
  assign bus.SDRAM_DQ_OUT = dq_out_q;
  assign bus.SDRAM_DQ_OE  = dq_oe_q;
  assign bus.SDRAM_DQM    = dqm_q;
  assign bus.XFER_DONE    = done_q;
  assign bus.XFER_ERR     = err_q;

endmodule
